serial_deserializer: RTL and testbench

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

---
 rtl/serial_deserializer.sv | 88 ++++++++
 tb/tb_serial_deserializer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// Serial-to-parallel converter with a single-entry valid/ready output stage.
// Bits are qualified by en; a full word is published in the same edge that
// samples its last bit. A word that completes while the output is still held
// is dropped and flagged with the sticky overrun bit.
module serial_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       d,
  input  logic                       en,
  input  logic                       clr,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt,
  output logic                       overrun
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             word_done;

  // Next-state logic: clear beats bit acceptance; completion either loads or overruns.
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    sr_shift  = MSB_FIRST ? {sr_q[WIDTH-2:0], d} : {d, sr_q[WIDTH-1:1]};
    word_done = en && !clr && (cnt_q == CntMax);

    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
      ovr_d = 1'b0;
    end else if (en) begin
      sr_d  = sr_shift;
      cnt_d = word_done ? '0 : cnt_q + 1'b1;
    end

    // Consumption; ready is meaningless without a pending word.
    if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end

    // Output slot is free if empty or being drained on this very edge.
    if (word_done) begin
      if (!valid_q || dout_ready) begin
        dout_d  = sr_shift;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign bit_cnt    = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: an MSB-first and an LSB-first instance share
// one input stream. Words are pushed into per-instance queues when issued and
// popped by monitors whenever a word is handed over (valid && ready).
module tb_serial_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       d = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       dout_ready = 1'b0;

  logic [7:0] m_dout, l_dout;
  logic       m_valid, l_valid;
  logic [2:0] m_cnt, l_cnt;
  logic       m_ovr, l_ovr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .en         (en),
    .clr        (clr),
    .dout       (m_dout),
    .dout_valid (m_valid),
    .dout_ready (dout_ready),
    .bit_cnt    (m_cnt),
    .overrun    (m_ovr)
  );

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .en         (en),
    .clr        (clr),
    .dout       (l_dout),
    .dout_valid (l_valid),
    .dout_ready (dout_ready),
    .bit_cnt    (l_cnt),
    .overrun    (l_ovr)
  );

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Inputs change 1 time unit after a rising edge and are applied by the next one.
  task automatic step(input logic bd, input logic be, input logic bc, input logic br);
    d = bd; en = be; clr = bc; dout_ready = br;
    @(posedge clk);
    #1;
  endtask

  // Shift w first-bit-first (w[7] first); ready driven only on the final bit edge.
  task automatic send_word(input logic [7:0] w, input logic push, input logic rdy_last);
    if (push) begin
      q_m.push_back(w);
      q_l.push_back(rev8(w));
    end
    for (int i = 7; i >= 0; i--) step(w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m_dout"}, {24'd0, m_dout}, 32'd0);
    chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    chk({tag, "_m_cnt"}, {29'd0, m_cnt}, 32'd0);
    chk({tag, "_m_ovr"}, {31'd0, m_ovr}, 32'd0);
    chk({tag, "_l_dout"}, {24'd0, l_dout}, 32'd0);
    chk({tag, "_l_valid"}, {31'd0, l_valid}, 32'd0);
  endtask

  // Monitors: a word handed over on the coming edge must match the queue head.
  always @(negedge clk) begin
    if (reset && m_valid && dout_ready) begin
      if (q_m.size() == 0) chk("m_unexpected_word", {24'd0, m_dout}, 32'hFFFF_FFFF);
      else chk("m_word", {24'd0, m_dout}, {24'd0, q_m.pop_front()});
    end
    if (reset && l_valid && dout_ready) begin
      if (q_l.size() == 0) chk("l_unexpected_word", {24'd0, l_dout}, 32'hFFFF_FFFF);
      else chk("l_word", {24'd0, l_dout}, {24'd0, q_l.pop_front()});
    end
  end

  initial begin
    logic [7:0] w;
    #2;
    chk_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Ready with nothing pending must be ignored.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle_ready_valid", {31'd0, m_valid}, 32'd0);

    // Basic MSB-first word, held.
    send_word(8'hA6, 1'b1, 1'b0);
    chk("a6_m_dout", {24'd0, m_dout}, 32'hA6);
    chk("a6_l_dout", {24'd0, l_dout}, 32'h65);
    chk("a6_valid", {31'd0, m_valid}, 32'd1);
    chk("a6_cnt", {29'd0, m_cnt}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("a6_hold", {24'd0, m_dout}, 32'hA6);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("a6_consumed", {31'd0, m_valid}, 32'd0);

    // Same word with a two-cycle en gap after bit 3.
    w = 8'hA6;
    q_m.push_back(w);
    q_l.push_back(rev8(w));
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        for (int g = 0; g < 2; g++) begin
          step(1'b1, 1'b0, 1'b0, 1'b0);
          chk("gap_cnt", {29'd0, m_cnt}, 32'd3);
        end
      end
      step(w[7-i], 1'b1, 1'b0, 1'b0);
    end
    chk("gap_dout", {24'd0, m_dout}, 32'hA6);
    chk("gap_valid", {31'd0, m_valid}, 32'd1);

    // Overrun: new word dropped while A6 is held.
    send_word(8'hFF, 1'b0, 1'b0);
    chk("ovr_dout", {24'd0, m_dout}, 32'hA6);
    chk("ovr_l_dout", {24'd0, l_dout}, 32'h65);
    chk("ovr_flag", {31'd0, m_ovr}, 32'd1);
    chk("ovr_cnt", {29'd0, m_cnt}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_sticky", {31'd0, m_ovr}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_ovr", {31'd0, m_ovr}, 32'd0);
    chk("clr_l_ovr", {31'd0, l_ovr}, 32'd0);
    chk("clr_valid", {31'd0, m_valid}, 32'd1);
    chk("clr_dout", {24'd0, m_dout}, 32'hA6);

    // Completion on the same edge that consumes the held word.
    send_word(8'h3C, 1'b1, 1'b1);
    chk("swap_dout", {24'd0, m_dout}, 32'h3C);
    chk("swap_l_dout", {24'd0, l_dout}, 32'h3C);
    chk("swap_valid", {31'd0, m_valid}, 32'd1);
    chk("swap_ovr", {31'd0, m_ovr}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("swap_drained", {31'd0, m_valid}, 32'd0);

    // Stream 0,1,1,0,0,1,0,1: LSB-first instance sees A6.
    send_word(8'h65, 1'b1, 1'b0);
    chk("lsb_dout", {24'd0, l_dout}, 32'hA6);
    chk("lsb_m_dout", {24'd0, m_dout}, 32'h65);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Clear mid-word; the bit offered with clr is discarded.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_clr_cnt", {29'd0, l_cnt}, 32'd3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("post_clr_cnt", {29'd0, l_cnt}, 32'd0);
    chk("post_clr_m_cnt", {29'd0, m_cnt}, 32'd0);
    send_word(8'h1E, 1'b1, 1'b0);
    chk("fresh_m_dout", {24'd0, m_dout}, 32'h1E);
    chk("fresh_l_dout", {24'd0, l_dout}, 32'h78);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-word with a word pending.
    send_word(8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_cnt", {29'd0, m_cnt}, 32'd5);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("async_rst");
    q_m.delete();
    q_l.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_word(8'h96, 1'b1, 1'b0);
    chk("post_rst_m_dout", {24'd0, m_dout}, 32'h96);
    chk("post_rst_l_dout", {24'd0, l_dout}, 32'h69);
    chk("post_rst_valid", {31'd0, m_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Every issued word must have been seen by the monitors.
    chk("m_queue_empty", q_m.size(), 32'd0);
    chk("l_queue_empty", q_l.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net in case the stimulus stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
